// File: rtl/rra_pkg.sv
// Definitions shared by the round-robin arbiter (rra) and its requester-side queue,
// so both ends agree on client count, ID width and arbiter state encodings.
package rra_pkg;

    localparam int REQS_DEFAULT = 4;

    // Client ID width; a single client still needs one bit to carry an index.
    function automatic int id_width(input int reqs);
        if (reqs <= 1) begin
            return 1;
        end else begin
            return $clog2(reqs);
        end
    endfunction

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4
    } rra_state_e;

endpackage

// File: rtl/rrq_fifo.sv
// Single-client synchronous FIFO. Storage is not reset; pointers and count are.
module rrq_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    output logic [DW-1:0]              head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          wr_en_s;
    logic          rd_en_s;

    // A push while full is dropped regardless of a same-edge pop.
    assign wr_en_s = push && !full;
    assign rd_en_s = pop && !empty;

    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;
    assign full  = (count_r == CW'(DEPTH));
    assign empty = (count_r == {CW{1'b0}});

    // Data storage write port.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({wr_en_s, rd_en_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/rra_req_queue.sv
// Per-client request queues feeding the round-robin arbiter: req from occupancy,
// grant-driven pop into a registered output, and sticky grant-protocol error flags.
module rra_req_queue
    import rra_pkg::*;
#(
    parameter int REQS  = REQS_DEFAULT,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [REQS-1:0]              push,
    input  logic [REQS*DW-1:0]           push_data,
    output logic [REQS-1:0]              full,
    output logic [REQS-1:0]              req,
    input  logic [REQS-1:0]              grant,
    output logic                         out_valid,
    output logic [DW-1:0]                out_data,
    output logic [id_width(REQS)-1:0]    out_id,
    output logic                         err_multi,
    output logic                         err_spurious
);

    localparam int IDW = id_width(REQS);
    localparam int CW  = $clog2(DEPTH) + 1;

    logic [REQS-1:0] pop_s;
    logic [REQS-1:0] empty_s;
    logic [DW-1:0]   head_s  [REQS];
    logic [CW-1:0]   count_s [REQS];
    logic [DW-1:0]   sel_data_s;
    logic [IDW-1:0]  sel_id_s;
    logic            spurious_s;
    logic            multi_s;

    for (genvar g = 0; g < REQS; g++) begin : g_fifo
        rrq_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[g]),
            .push_data (push_data[g*DW +: DW]),
            .pop       (pop_s[g]),
            .head      (head_s[g]),
            .count     (count_s[g]),
            .full      (full[g]),
            .empty     (empty_s[g])
        );
    end

    assign req = ~empty_s;

    // Grant decode: a multi-hot grant pops nothing; a grant to an empty FIFO is flagged.
    always_comb begin
        pop_s      = {REQS{1'b0}};
        sel_data_s = {DW{1'b0}};
        sel_id_s   = {IDW{1'b0}};
        spurious_s = 1'b0;
        multi_s    = 1'b0;
        if ($countones(grant) > 1) begin
            multi_s = 1'b1;
        end else if (grant != {REQS{1'b0}}) begin
            for (int i = 0; i < REQS; i++) begin
                if (grant[i]) begin
                    if (count_s[i] != {CW{1'b0}}) begin
                        pop_s[i]   = 1'b1;
                        sel_data_s = head_s[i];
                        sel_id_s   = IDW'(i);
                    end else begin
                        spurious_s = 1'b1;
                    end
                end else begin
                    pop_s[i] = 1'b0;
                end
            end
        end else begin
            multi_s = 1'b0;
        end
    end

    // Output register and sticky error flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid    <= 1'b0;
            out_data     <= {DW{1'b0}};
            out_id       <= {IDW{1'b0}};
            err_multi    <= 1'b0;
            err_spurious <= 1'b0;
        end else begin
            out_valid <= |pop_s;
            if (|pop_s) begin
                out_data <= sel_data_s;
                out_id   <= sel_id_s;
            end else begin
                out_data <= out_data;
                out_id   <= out_id;
            end
            err_multi    <= err_multi | multi_s;
            err_spurious <= err_spurious | spurious_s;
        end
    end

endmodule

// File: doc/rra_req_queue.md
# rra_req_queue

Requester-side companion to the round-robin arbiter (`rra`). It buffers data words from up to REQS clients in per-client FIFOs and drives the arbiter's `req` vector from FIFO occupancy. On each single-cycle arbiter `grant` it pops the granted client's head word and forwards it downstream with the client ID. It also checks the grant protocol and records violations in sticky error flags.

## Interface
- REQS, 4: number of clients; must match the arbiter's REQS.
- DW, 8: data word width.
- DEPTH, 4: per-client FIFO depth; must be a power of 2 and at least 2.

- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- push  in  REQS  per-client write strobe
- push_data  in  REQS*DW  client i data is bits [i*DW +: DW]
- full  out  REQS  client i FIFO holds DEPTH words
- req  out  REQS  to arbiter; req[i] = FIFO i non-empty
- grant  in  REQS  from arbiter; registered, one-hot or zero
- out_valid  out  1  one-cycle pulse: word popped
- out_data  out  DW  popped word
- out_id  out  $clog2(REQS)  index of client served
- err_multi  out  1  sticky: grant seen with more than one bit set
- err_spurious  out  1  sticky: grant to a client whose FIFO is empty

## Operation
- Per client: a FIFO with wr_ptr, rd_ptr and count, where count is $clog2(DEPTH)+1 bits. Pointers wrap modulo DEPTH.
- req[i] = (count_i != 0). This is combinational from registered count, so it is glitch-free.
- full[i] = (count_i == DEPTH).
- Push: when push[i] is high and full[i] is low at a clock edge, write push_data slice i and increment count_i.
  - A push while full is dropped, even if a pop occurs on the same edge.
- Grant decode at each edge:
  - grant == 0: no action.
  - grant one-hot at bit k, count_k != 0: pop the head of FIFO k. Register out_data = head, out_id = k, out_valid = 1.
  - grant one-hot at bit k, count_k == 0: no pop, out_valid = 0, set err_spurious.
    - This is tolerated. The arbiter samples req one cycle before it grants, so it can grant a client whose last word was already served.
  - grant multi-hot: no pop in any FIFO, out_valid = 0, set err_multi.
- A simultaneous push and valid pop on the same client leaves count unchanged. Both data paths are updated.
- Pushes on all clients on the same edge are independent and all accepted unless the client's FIFO is full.
- Error flags are sticky. Only reset clears them.
- FIFO storage is not reset. Pointers, counts and all outputs are reset.

## Timing
- Reset values: req=0, full=0, out_valid=0, out_data=0, out_id=0, err_multi=0, err_spurious=0.
- Reset asserted mid-transfer empties all FIFOs immediately and drops req the same cycle (asynchronous). Any in-flight grant is ignored while rst is low.
- Push-to-req latency: push sampled at edge t gives req[i] high after t.
- Grant-to-output latency: grant sampled at edge t gives out_valid, out_data and out_id after t, held for exactly one cycle.
- Pop-to-req: a pop at edge t that empties the FIFO drops req[i] after t.
- Throughput: one pop per cycle maximum across all clients, matching the arbiter's one grant per cycle.
- No backpressure on the output. The downstream consumer must accept every out_valid pulse.

## Structure
- Shared package `rra_pkg` holds:
  - REQS default
  - the ID width function/constant ($clog2(REQS))
  - the arbiter state encodings s0..s4, shared with `rra` so both ends agree
- Sub-module `rrq_fifo`: single-client synchronous FIFO with push, pop, head, count, full and empty.
  - Instantiated REQS times with a generate loop.
  - The top level holds grant decode, the output register and the error flags.

## Test plan
- Reset then push 0xA1 on client 0: req=0001 next cycle; drive grant=0001 → out_valid=1, out_data=0xA1, out_id=0 one cycle later, req=0000.
- Push 0x11, 0x22, 0x33, 0x44 to client 2, then a fifth push 0x55: full[2]=1 after the fourth push, fifth push dropped; four grants=0100 return 0x11..0x44 in order.
- Push and grant on client 1 on the same edge with count=2: count stays 2, popped word is the old head, new word is appended at the tail.
- Grant=0010 with client 1 empty → out_valid=0, err_spurious=1 and stays 1 until rst; grant=0011 → err_multi=1, no FIFO changes.
- Closed loop with `rra`: load 2 words into each of 4 clients → every word emerges exactly once, out_id order follows the round-robin rotation, all FIFOs empty, err_multi=0.
- Assert rst low while 3 clients have pending data and grant is active → req, out_valid and counts go to 0 immediately; after release, a new push to client 3 is served normally.
